// File: rtl/pc_stk.sv
// Fetch-stage program counter with a hardware return stack, stall and one vectored interrupt.
// Define PC_IRQ_EN to build the interrupt logic; without it irq is ignored.
module pc_stk #(
    parameter int               NBITS  = 8,
    parameter int               SDEPTH = 8,
    parameter logic [NBITS-1:0] IVEC   = NBITS'(1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic                      call,
    input  logic                      ret,
    input  logic [NBITS-1:0]          data,
    input  logic                      irq,
    output logic                      irq_ack,
    output logic                      in_isr,
    output logic [NBITS-1:0]          nxt,
    output logic [NBITS-1:0]          addr,
    output logic [$clog2(SDEPTH):0]   sp,
    output logic                      err
);

    localparam int              AW      = $clog2(SDEPTH);
    localparam int              SPW     = AW + 1;
    localparam logic [SPW-1:0]  SP_FULL = SPW'(SDEPTH);

    logic [NBITS-1:0] addr_q, addr_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             err_q, err_d;
    logic [NBITS-1:0] stack_mem [SDEPTH];

    logic             irq_take;
    logic             ret_sel;
    logic             push;
    logic [NBITS-1:0] push_val;
    logic             stack_empty;
    logic             stack_full;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;

    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SP_FULL);
    assign top_idx     = AW'(sp_q - 1'b1);
    assign wr_idx      = sp_q[AW-1:0];

`ifdef PC_IRQ_EN
    logic           in_isr_q, in_isr_d;
    logic           irq_ack_q, irq_ack_d;
    logic [SPW-1:0] isr_sp_q, isr_sp_d;

    assign irq_take = irq & en & ~in_isr_q;
`else
    logic unused_irq;

    assign irq_take   = 1'b0;
    assign unused_irq = ^{irq, IVEC};
`endif

    // A call returns past itself (addr + 1); an interrupt returns to the
    // unchanged addr so the instruction it displaced is fetched again.
    always_comb begin
        nxt      = addr_q;
        ret_sel  = 1'b0;
        push     = 1'b0;
        push_val = addr_q;
        if (irq_take) begin
            nxt      = IVEC;
            push     = 1'b1;
            push_val = addr_q;
        end else if (ret) begin
            ret_sel = 1'b1;
            nxt     = stack_empty ? addr_q : stack_mem[top_idx];
        end else if (call) begin
            nxt      = data;
            push     = en;
            push_val = addr_q + 1'b1;
        end else if (load) begin
            nxt = data;
        end
    end

    always_comb begin
        addr_d = addr_q;
        sp_d   = sp_q;
        err_d  = err_q;
        if (en) begin
            addr_d = nxt + 1'b1;
            if (push) begin
                if (stack_full) err_d = 1'b1;
                else            sp_d  = sp_q + 1'b1;
            end else if (ret_sel) begin
                if (stack_empty) err_d = 1'b1;
                else             sp_d  = sp_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            sp_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            sp_q   <= sp_d;
            err_q  <= err_d;
        end
    end

    // Stack storage carries no reset; entries above sp are never read.
    always_ff @(posedge clk) begin
        if (push && !stack_full) stack_mem[wr_idx] <= push_val;
    end

`ifdef PC_IRQ_EN
    // The ISR ends when the stack unwinds back to its depth at entry.
    always_comb begin
        in_isr_d  = in_isr_q;
        isr_sp_d  = isr_sp_q;
        irq_ack_d = irq_take;
        if (irq_take) begin
            in_isr_d = 1'b1;
            isr_sp_d = sp_q;
        end else if (en && ret_sel && in_isr_q && (sp_d == isr_sp_q)) begin
            in_isr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_isr_q  <= 1'b0;
            irq_ack_q <= 1'b0;
            isr_sp_q  <= '0;
        end else begin
            in_isr_q  <= in_isr_d;
            irq_ack_q <= irq_ack_d;
            isr_sp_q  <= isr_sp_d;
        end
    end

    assign in_isr  = in_isr_q;
    assign irq_ack = irq_ack_q;
`else
    assign in_isr  = 1'b0;
    assign irq_ack = 1'b0;
`endif

    assign addr = addr_q;
    assign sp   = sp_q;
    assign err  = err_q;

endmodule

// File: tb/tb_pc_stk.sv
// Directed self-checking bench for pc_stk (NBITS=8, SDEPTH=2, IVEC=1).
// Interrupt scenarios follow the PC_IRQ_EN build setting.
module tb_pc_stk;

    localparam int NBITS  = 8;
    localparam int SDEPTH = 2;

    logic             clk;
    logic             rst;
    logic             en;
    logic             load;
    logic             call;
    logic             ret;
    logic [NBITS-1:0] data;
    logic             irq;
    logic             irq_ack;
    logic             in_isr;
    logic [NBITS-1:0] nxt;
    logic [NBITS-1:0] addr;
    logic [1:0]       sp;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_stk #(
        .NBITS (NBITS),
        .SDEPTH(SDEPTH),
        .IVEC  (8'd1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .load   (load),
        .call   (call),
        .ret    (ret),
        .data   (data),
        .irq    (irq),
        .irq_ack(irq_ack),
        .in_isr (in_isr),
        .nxt    (nxt),
        .addr   (addr),
        .sp     (sp),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        en   = 1'b0;
        load = 1'b0;
        call = 1'b0;
        ret  = 1'b0;
        data = '0;
        irq  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        en  = 1'b1;
        rst = 1'b0;
        tick();
        n_checks++; if (addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", addr); end
        n_checks++; if (sp !== 2'd0) begin n_fail++; $display("FAIL reset_sp got %0d want 0", sp); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", err); end
        n_checks++; if (in_isr !== 1'b0) begin n_fail++; $display("FAIL reset_in_isr got %0b want 0", in_isr); end
        n_checks++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL reset_irq_ack got %0b want 0", irq_ack); end
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++; if (addr !== 8'(i)) begin n_fail++; $display("FAIL count_addr got %0d want %0d", addr, i); end
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (addr !== 8'd4) begin n_fail++; $display("FAIL stall_addr got %0d want 4", addr); end
        end
    endtask

    task automatic test_jump_wrap();
        en   = 1'b1;
        load = 1'b1;
        data = 8'hFE;
        #1;
        n_checks++; if (nxt !== 8'hFE) begin n_fail++; $display("FAIL load_nxt got %h want fe", nxt); end
        tick();
        n_checks++; if (addr !== 8'hFF) begin n_fail++; $display("FAIL load_addr got %h want ff", addr); end
        load = 1'b0;
        tick();
        n_checks++; if (addr !== 8'h00) begin n_fail++; $display("FAIL wrap_addr got %h want 00", addr); end
    endtask

    task automatic test_call_ret();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (addr !== 8'd5) begin n_fail++; $display("FAIL pre_call_addr got %0d want 5", addr); end
        call = 1'b1;
        data = 8'd20;
        #1;
        n_checks++; if (nxt !== 8'd20) begin n_fail++; $display("FAIL call1_nxt got %0d want 20", nxt); end
        tick();
        n_checks++; if (addr !== 8'd21 || sp !== 2'd1) begin n_fail++; $display("FAIL call1 got addr=%0d sp=%0d want addr=21 sp=1", addr, sp); end
        data = 8'd40;
        tick();
        n_checks++; if (addr !== 8'd41 || sp !== 2'd2) begin n_fail++; $display("FAIL call2 got addr=%0d sp=%0d want addr=41 sp=2", addr, sp); end
        call = 1'b0;
        ret  = 1'b1;
        #1;
        n_checks++; if (nxt !== 8'd22) begin n_fail++; $display("FAIL ret1_nxt got %0d want 22", nxt); end
        tick();
        n_checks++; if (addr !== 8'd23 || sp !== 2'd1) begin n_fail++; $display("FAIL ret1 got addr=%0d sp=%0d want addr=23 sp=1", addr, sp); end
        #1;
        n_checks++; if (nxt !== 8'd6) begin n_fail++; $display("FAIL ret2_nxt got %0d want 6", nxt); end
        tick();
        n_checks++; if (addr !== 8'd7 || sp !== 2'd0) begin n_fail++; $display("FAIL ret2 got addr=%0d sp=%0d want addr=7 sp=0", addr, sp); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL nest_err got %0b want 0", err); end
        ret = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        en   = 1'b1;
        call = 1'b1;
        data = 8'd30;
        tick();
        data = 8'd40;
        tick();
        n_checks++; if (sp !== 2'd2 || err !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got sp=%0d err=%0b want sp=2 err=0", sp, err); end
        data = 8'd50;
        tick();
        n_checks++; if (sp !== 2'd2 || err !== 1'b1 || addr !== 8'd51) begin n_fail++; $display("FAIL ovf got sp=%0d err=%0b addr=%0d want sp=2 err=1 addr=51", sp, err, addr); end
        call = 1'b0;
        tick();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b want 1", err); end
        do_reset();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_reset got %0b want 0", err); end
        en  = 1'b1;
        ret = 1'b1;
        #1;
        n_checks++; if (nxt !== 8'd0) begin n_fail++; $display("FAIL unf_nxt got %0d want 0", nxt); end
        tick();
        n_checks++; if (addr !== 8'd1 || sp !== 2'd0 || err !== 1'b1) begin n_fail++; $display("FAIL unf got addr=%0d sp=%0d err=%0b want addr=1 sp=0 err=1", addr, sp, err); end
        ret = 1'b0;
    endtask

`ifdef PC_IRQ_EN
    task automatic test_irq();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        irq  = 1'b1;
        call = 1'b1;
        data = 8'd50;
        #1;
        n_checks++; if (nxt !== 8'd1) begin n_fail++; $display("FAIL irq_nxt got %0d want 1", nxt); end
        tick();
        n_checks++; if (irq_ack !== 1'b1 || addr !== 8'd2 || in_isr !== 1'b1 || sp !== 2'd1) begin n_fail++; $display("FAIL irq_take got ack=%0b addr=%0d isr=%0b sp=%0d want 1 2 1 1", irq_ack, addr, in_isr, sp); end
        call = 1'b0;
        tick();
        n_checks++; if (irq_ack !== 1'b0 || addr !== 8'd3 || in_isr !== 1'b1 || sp !== 2'd1) begin n_fail++; $display("FAIL irq_no_reentry got ack=%0b addr=%0d isr=%0b sp=%0d want 0 3 1 1", irq_ack, addr, in_isr, sp); end
        ret = 1'b1;
        #1;
        n_checks++; if (nxt !== 8'd10) begin n_fail++; $display("FAIL isr_ret_nxt got %0d want 10", nxt); end
        tick();
        n_checks++; if (addr !== 8'd11 || in_isr !== 1'b0 || sp !== 2'd0) begin n_fail++; $display("FAIL isr_ret got addr=%0d isr=%0b sp=%0d want 11 0 0", addr, in_isr, sp); end
        ret = 1'b0;
        tick();
        n_checks++; if (irq_ack !== 1'b1 || addr !== 8'd2 || in_isr !== 1'b1 || sp !== 2'd1) begin n_fail++; $display("FAIL irq_again got ack=%0b addr=%0d isr=%0b sp=%0d want 1 2 1 1", irq_ack, addr, in_isr, sp); end
        irq = 1'b0;
    endtask
`else
    task automatic test_irq();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        irq = 1'b1;
        #1;
        n_checks++; if (nxt !== 8'd3) begin n_fail++; $display("FAIL irq_ignored_nxt got %0d want 3", nxt); end
        tick();
        n_checks++; if (irq_ack !== 1'b0 || in_isr !== 1'b0 || addr !== 8'd4 || sp !== 2'd0) begin n_fail++; $display("FAIL irq_ignored got ack=%0b isr=%0b addr=%0d sp=%0d want 0 0 4 0", irq_ack, in_isr, addr, sp); end
        irq = 1'b0;
    endtask
`endif

    task automatic test_stall_reset();
        do_reset();
        en  = 1'b0;
        irq = 1'b1;
        tick();
        n_checks++; if (irq_ack !== 1'b0 || in_isr !== 1'b0 || addr !== 8'd0) begin n_fail++; $display("FAIL stall_irq got ack=%0b isr=%0b addr=%0d want 0 0 0", irq_ack, in_isr, addr); end
`ifdef PC_IRQ_EN
        en = 1'b1;
        tick();
        n_checks++; if (irq_ack !== 1'b1 || addr !== 8'd2) begin n_fail++; $display("FAIL pending_irq got ack=%0b addr=%0d want 1 2", irq_ack, addr); end
`endif
        do_reset();
        en   = 1'b1;
        call = 1'b1;
        data = 8'd30;
        tick();
        data = 8'd40;
        tick();
        call = 1'b0;
        n_checks++; if (sp !== 2'd2) begin n_fail++; $display("FAIL pre_async_sp got %0d want 2", sp); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (addr !== 8'd0 || sp !== 2'd0 || err !== 1'b0 || in_isr !== 1'b0 || irq_ack !== 1'b0 || nxt !== 8'd0) begin n_fail++; $display("FAIL async_reset got addr=%0d sp=%0d err=%0b isr=%0b ack=%0b nxt=%0d want all 0", addr, sp, err, in_isr, irq_ack, nxt); end
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (addr !== 8'd1) begin n_fail++; $display("FAIL post_reset_addr got %0d want 1", addr); end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_jump_wrap();
        test_call_ret();
        test_overflow();
        test_irq();
        test_stall_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
